vector_alu: RTL and testbench
=============================

VECTOR_ALU -- requirements
Module: vector_alu

Interface
REQ-001 SHALL have parameter LANES, default 4, number of independent data lanes.
REQ-002 SHALL have parameter WIDTH, default 16, bits per lane; legal values are powers of two, 8 to 32.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operation request valid.
REQ-006 SHALL have port in_ready  output  1  operation accepted when in_valid && in_ready.
REQ-007 SHALL have port op  input  4  opcode.
REQ-008 SHALL have ports a, b  input  LANES*WIDTH  packed lane operands, lane 0 in the LSBs.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result when out_valid && out_ready.
REQ-011 SHALL have port result  output  LANES*WIDTH  packed lane results.
REQ-012 SHALL have ports zero, negative  output  LANES  per-lane CMP flags, qualified by out_valid.
REQ-013 SHALL have ports flag_z, flag_n  output  1  sticky aggregate flags from the last accepted CMP.
REQ-014 SHALL have port illegal  output  1  the current result comes from an unsupported opcode; qualified by out_valid.

Function
REQ-015 SHALL decode op as follows:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 LSL, 5 CMP: each modulo 2^WIDTH per lane.
- 6, 7, 8 PASS: result = a.
- 9 to 12 NOP: result = 0, illegal = 0.
- 13 LSR, 14 XOR.
- 15 MUL: result = low WIDTH bits of a*b, unsigned.
REQ-016 SHALL, for LSL and LSR, take the per-lane shift amount from b lane bits [log2(WIDTH)-1:0] and ignore the upper bits.
REQ-017 SHALL, for CMP, produce:
- result = a-b per lane.
- zero[i] = (a_i == b_i).
- negative[i] = signed a_i < signed b_i, correct under overflow.
REQ-018 SHALL drive zero and negative to all-zero for every op other than CMP.
REQ-019 SHALL, on CMP acceptance, set flag_z = AND of the lane zero bits and flag_n = OR of the lane negative bits; other ops SHALL leave both unchanged.
REQ-020 SHALL run a state machine with states IDLE, BUSY and HOLD:
- IDLE to HOLD on a single-cycle op.
- IDLE to BUSY on MUL.
- BUSY to HOLD after WIDTH iteration cycles.
- HOLD to IDLE on out_ready; or HOLD to HOLD or BUSY on out_ready together with a new acceptance.
REQ-021 SHALL register single-cycle op results with out_valid asserted the cycle after acceptance, a latency of 1.
REQ-022 SHALL compute MUL by shift-add on all lanes in parallel, with out_valid asserted WIDTH+1 cycles after acceptance.
REQ-023 SHALL drive in_ready = (state==IDLE) || (state==HOLD && out_ready), so back-to-back single-cycle ops sustain one op per cycle.
REQ-024 SHALL keep in_ready at 0 throughout BUSY.
REQ-025 SHALL hold result, zero, negative and illegal stable while out_valid && !out_ready.
REQ-026 SHALL sample op, a and b only at acceptance; input changes after acceptance SHALL NOT affect the result.

Reset
REQ-027 SHALL, while rst_n is 0 at a clock edge, enter IDLE, abort any in-flight MUL, and clear out_valid, result, zero, negative, flag_z, flag_n and illegal to 0.
REQ-028 SHALL drive in_ready to 1 on the first cycle after rst_n returns to 1.

Configuration
REQ-029 SHALL, with macro VALU_MUL_EN defined, include the BUSY state and the shift-add multiplier.
REQ-030 SHALL, without VALU_MUL_EN, treat op 15 as a single-cycle op returning result 0 and illegal = 1, and SHALL omit the BUSY state and the multiplier hardware.

Structure
REQ-031 SHALL place the following in shared package valu_pkg:
- opcode enum.
- state enum.
- default LANES and WIDTH constants.
REQ-032 SHALL instantiate one sub-module valu_lane per lane via generate; it holds the combinational lane datapath and the lane's multiplier accumulator, and vector_alu owns the state machine, handshake and sticky flags.

Verification
REQ-033 SHALL cover ADD with a={0x1234,0x7FFF,0xFFFF,0x0001} and b={0x0000,1,1,1} (lane3..lane0) -> result={0x1234,0x8000,0x0000,0x0002}, with out_valid exactly 1 cycle after acceptance.
REQ-034 SHALL cover the CMP sequence:
- a={7,0x8000,3,5}, b={2,1,4,5} -> zero=4'b0001, negative=4'b0110, flag_z=0, flag_n=1.
- Then ADD -> flags unchanged.
- Then CMP with a==b -> flag_z=1, flag_n=0.
REQ-035 SHALL cover MUL with VALU_MUL_EN:
- 0x0003*0x0005 -> 0x000F, out_valid 17 cycles after acceptance, in_ready 0 for 16 cycles.
- 0x0100*0x0100 -> 0x0000.
REQ-036 SHALL cover backpressure:
- out_ready held 0 for 3 cycles -> result stable and in_ready 0.
- Raising out_ready with a pending in_valid -> the new op is accepted in that same cycle.
REQ-037 SHALL cover shift masking and reset:
- LSL 0x0001 by b=17 -> 0x0002.
- rst_n=0 at BUSY cycle 5 -> next cycle out_valid=0, result=0, in_ready=1.
REQ-038 SHALL cover op 15 without VALU_MUL_EN -> result 0, illegal=1, latency 1.

Source files
------------

// File: rtl/valu_pkg.sv
// Shared opcode/state types and default geometry for the vector ALU.
// The BUSY state exists only when VALU_MUL_EN is defined.
package valu_pkg;

    localparam int DEF_LANES = 4;
    localparam int DEF_WIDTH = 16;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_LSL   = 4'd4,
        OP_CMP   = 4'd5,
        OP_PASS0 = 4'd6,
        OP_PASS1 = 4'd7,
        OP_PASS2 = 4'd8,
        OP_NOP0  = 4'd9,
        OP_NOP1  = 4'd10,
        OP_NOP2  = 4'd11,
        OP_NOP3  = 4'd12,
        OP_LSR   = 4'd13,
        OP_XOR   = 4'd14,
        OP_MUL   = 4'd15
    } op_e;

`ifdef VALU_MUL_EN
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_HOLD} state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_HOLD} state_e;
`endif

endpackage

// File: rtl/valu_lane.sv
// One lane: combinational single-cycle datapath plus, with VALU_MUL_EN,
// a shift-add multiplier accumulator stepped once per BUSY cycle.
module valu_lane
    import valu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mul_start,
    input  logic             mul_step,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             neg,
    output logic             illegal,
    output logic [WIDTH-1:0] mul_res
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] sh;
    assign sh = b[SHW-1:0];

    always_comb begin
        res     = '0;
        zero    = 1'b0;
        neg     = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_LSL:  res = a << sh;
            OP_CMP: begin
                res  = a - b;
                zero = (a == b);
                neg  = $signed(a) < $signed(b);
            end
            OP_PASS0, OP_PASS1, OP_PASS2: res = a;
            OP_LSR:  res = a >> sh;
            OP_XOR:  res = a ^ b;
`ifndef VALU_MUL_EN
            OP_MUL:  illegal = 1'b1;
`endif
            default: res = '0;
        endcase
    end

`ifdef VALU_MUL_EN
    logic [WIDTH-1:0] mcand, mplier, acc;

    // mul_res is the accumulator value after the current step
    assign mul_res = mplier[0] ? acc + mcand : acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (mul_start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if (mul_step) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= mul_res;
        end
    end
`else
    logic unused_mul;
    assign unused_mul = ^{clk, rst_n, mul_start, mul_step};
    assign mul_res    = '0;
`endif

endmodule

// File: rtl/vector_alu.sv
// Multi-lane vector ALU with valid/ready handshake, sticky CMP flags and an
// optional multi-cycle shift-add multiplier enabled by VALU_MUL_EN.
module vector_alu
    import valu_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             op,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] result,
    output logic [LANES-1:0]       zero,
    output logic [LANES-1:0]       negative,
    output logic                   flag_z,
    output logic                   flag_n,
    output logic                   illegal
);

    state_e state;
    op_e    op_i;
    logic   accept, is_mul, mul_step;

    logic [LANES*WIDTH-1:0] lane_res, mul_res;
    logic [LANES-1:0]       lane_zero, lane_neg, lane_ill;

    assign op_i      = op_e'(op);
    assign in_ready  = (state == ST_IDLE) || (state == ST_HOLD && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_HOLD);

`ifdef VALU_MUL_EN
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
    logic [SHW-1:0] cnt;
    assign is_mul   = (op_i == OP_MUL);
    assign mul_step = (state == ST_BUSY);
`else
    assign is_mul   = 1'b0;
    assign mul_step = 1'b0;
`endif

    genvar i;
    generate
        for (i = 0; i < LANES; i++) begin : g_lane
            valu_lane #(.WIDTH(WIDTH)) u_lane (
                .clk       (clk),
                .rst_n     (rst_n),
                .op        (op_i),
                .a         (a[i*WIDTH +: WIDTH]),
                .b         (b[i*WIDTH +: WIDTH]),
                .mul_start (accept && is_mul),
                .mul_step  (mul_step),
                .res       (lane_res[i*WIDTH +: WIDTH]),
                .zero      (lane_zero[i]),
                .neg       (lane_neg[i]),
                .illegal   (lane_ill[i]),
                .mul_res   (mul_res[i*WIDTH +: WIDTH])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            result   <= '0;
            zero     <= '0;
            negative <= '0;
            illegal  <= 1'b0;
            flag_z   <= 1'b0;
            flag_n   <= 1'b0;
`ifdef VALU_MUL_EN
            cnt      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        if (is_mul) begin
`ifdef VALU_MUL_EN
                            state <= ST_BUSY;
                            cnt   <= '0;
`endif
                        end else begin
                            state    <= ST_HOLD;
                            result   <= lane_res;
                            zero     <= lane_zero;
                            negative <= lane_neg;
                            illegal  <= |lane_ill;
                            if (op_i == OP_CMP) begin
                                flag_z <= &lane_zero;
                                flag_n <= |lane_neg;
                            end
                        end
                    end else if (state == ST_HOLD && out_ready) begin
                        state <= ST_IDLE;
                    end
                end
`ifdef VALU_MUL_EN
                ST_BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state    <= ST_HOLD;
                        result   <= mul_res;
                        zero     <= '0;
                        negative <= '0;
                        illegal  <= 1'b0;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_alu.sv
// Scoreboard bench for vector_alu: stimulus pushes model expectations, a
// monitor checks every presented result, its stability and its latency.
module tb_vector_alu;

    localparam int L = 4;
    localparam int W = 16;
    localparam int M = (1 << W) - 1;
`ifdef VALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic           clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [3:0]     op = '0;
    logic [L*W-1:0] a = '0, b = '0;
    logic           in_ready, out_valid, flag_z, flag_n, illegal;
    logic [L*W-1:0] result;
    logic [L-1:0]   zero, negative;

    vector_alu #(.LANES(L), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .negative(negative),
        .flag_z(flag_z), .flag_n(flag_n), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [L*W-1:0] res;
        logic [L-1:0]   z, n;
        logic           ill, fz, fn;
        int             acc_cyc, lat;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0, checks = 0, cyc = 0;
    bit   m_fz = 0, m_fn = 0, rnd_rdy = 0, have_start = 0;
    int   pres = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int sgn(input int unsigned x);
        return (x >= (1 << (W - 1))) ? int'(x) - (1 << W) : int'(x);
    endfunction

    // Reference behaviour from the opcode table, lane by lane
    function automatic exp_t model(input logic [3:0] o, input logic [L*W-1:0] x, input logic [L*W-1:0] y);
        exp_t e;
        e.res = '0; e.z = '0; e.n = '0; e.ill = 1'b0; e.fz = 1'b0; e.fn = 1'b0;
        e.acc_cyc = 0;
        e.lat = (o == 4'd15 && MUL_EN) ? W + 1 : 1;
        for (int i = 0; i < L; i++) begin
            int unsigned p, q, r;
            p = x[i*W +: W];
            q = y[i*W +: W];
            r = 0;
            case (o)
                4'd0: r = (p + q) & M;
                4'd1: r = (p - q) & M;
                4'd2: r = p & q;
                4'd3: r = p | q;
                4'd4: r = (p << (q % W)) & M;
                4'd5: begin
                    r = (p - q) & M;
                    e.z[i] = (p == q);
                    e.n[i] = sgn(p) < sgn(q);
                end
                4'd6, 4'd7, 4'd8: r = p;
                4'd13: r = p >> (q % W);
                4'd14: r = p ^ q;
                4'd15: begin
                    if (MUL_EN) r = (p * q) & M;
                    else e.ill = 1'b1;
                end
                default: r = 0;
            endcase
            e.res[i*W +: W] = r[W-1:0];
        end
        return e;
    endfunction

    task automatic issue(input logic [3:0] o, input logic [L*W-1:0] x, input logic [L*W-1:0] y,
                         input bit force_rdy, output int waits);
        exp_t e;
        bit   ok;
        waits = 0;
        ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; op = o; a = x; b = y;
        if (force_rdy) out_ready = 1'b1;
        while (!ok) begin
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
            #4;
            if (in_ready) ok = 1'b1;
            else begin
                waits++;
                if (waits > 100) begin
                    chk("accept_timeout", 64'(waits), 64'd0);
                    in_valid = 1'b0;
                    return;
                end
                @(negedge clk);
            end
        end
        @(posedge clk);
        #1;
        e = model(o, x, y);
        if (o == 4'd5) begin
            m_fz = &e.z;
            m_fn = |e.n;
        end
        e.fz = m_fz; e.fn = m_fn; e.acc_cyc = cyc;
        exp_q.push_back(e);
        in_valid = 1'b0;
        op = 4'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
    endtask

    // Monitor: every presented cycle is checked against the queue head
    always @(negedge clk) begin
        #2;
        if (!rst_n) have_start = 1'b0;
        else if (out_valid) begin
            if (!have_start) begin pres = cyc; have_start = 1'b1; end
            if (exp_q.size() == 0) chk("spurious_valid", 64'(out_valid), 64'd0);
            else begin
                chk("result", result, exp_q[0].res);
                chk("zero", 64'(zero), 64'(exp_q[0].z));
                chk("negative", 64'(negative), 64'(exp_q[0].n));
                chk("illegal", 64'(illegal), 64'(exp_q[0].ill));
                chk("flag_z", 64'(flag_z), 64'(exp_q[0].fz));
                chk("flag_n", 64'(flag_n), 64'(exp_q[0].fn));
                if (out_ready) begin
                    chk("latency", 64'(pres - exp_q[0].acc_cyc + 1), 64'(exp_q[0].lat));
                    void'(exp_q.pop_front());
                    have_start = 1'b0;
                end
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [L*W-1:0] va, vb;

        repeat (3) @(negedge clk);
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_zero_neg", 64'({zero, negative}), 64'd0);
        chk("rst_flags", 64'({flag_z, flag_n, illegal}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        issue(4'd0, {16'h1234, 16'h7FFF, 16'hFFFF, 16'h0001},
                    {16'h0000, 16'h0001, 16'h0001, 16'h0001}, 1'b0, w);
        chk("add_accept_wait", 64'(w), 64'd0);

        issue(4'd5, {16'd7, 16'h8000, 16'd3, 16'd5}, {16'd2, 16'd1, 16'd4, 16'd5}, 1'b0, w);
        issue(4'd0, {16'd1, 16'd2, 16'd3, 16'd4}, {16'd5, 16'd6, 16'd7, 16'd8}, 1'b0, w);
        issue(4'd5, {16'hAAAA, 16'h8000, 16'h0000, 16'hFFFF},
                    {16'hAAAA, 16'h8000, 16'h0000, 16'hFFFF}, 1'b0, w);

        issue(4'd4, {4{16'h0001}}, {4{16'd17}}, 1'b0, w);
        issue(4'd13, {4{16'h8000}}, {16'd33, 16'd15, 16'd4, 16'd0}, 1'b0, w);

        if (MUL_EN) begin
            issue(4'd15, {4{16'h0003}}, {4{16'h0005}}, 1'b0, w);
            for (int i = 0; i < W; i++) begin
                @(negedge clk);
                #2;
                chk("busy_in_ready", 64'(in_ready), 64'd0);
            end
            issue(4'd15, {4{16'h0100}}, {4{16'h0100}}, 1'b0, w);
        end else begin
            issue(4'd15, {4{16'h0003}}, {4{16'h0005}}, 1'b0, w);
        end
        drain();

        out_ready = 1'b0;
        issue(4'd14, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        issue(4'd1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, w);
        chk("bp_same_cycle_accept", 64'(w), 64'd0);
        drain();

        issue(4'd5, {16'd0, 16'd0, 16'd0, 16'd1}, {16'd1, 16'd1, 16'd1, 16'd2}, 1'b0, w);
        drain();
        out_ready = 1'b0;
        issue(MUL_EN ? 4'd15 : 4'd5, {4{16'h1234}}, {4{16'h0007}}, 1'b0, w);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        m_fz = 1'b0; m_fn = 1'b0;
        @(negedge clk);
        #2;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_result", result, 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_flags", 64'({flag_z, flag_n}), 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        #2;
        chk("post_abort_out_valid", 64'(out_valid), 64'd0);

        rnd_rdy = 1'b1;
        for (int k = 0; k < 300; k++) begin
            va = {$urandom, $urandom};
            vb = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) vb = va ^ (64'($urandom_range(0, 1)) << (16 * $urandom_range(0, 3)));
            issue(4'($urandom_range(0, 15)), va, vb, 1'b0, w);
        end
        rnd_rdy = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
